// File: rtl/core_pkg.sv
// Shared decode-side definitions: opcode constants, memory-op classification,
// min helper and the dispatch-group valid encoding.
// Latency: n/a (package). Backpressure: n/a.
package core_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  // Dispatch groups are always right-justified: only these three encodings exist.
  typedef enum logic [1:0] {
    GRP_NONE = 2'b00,
    GRP_ONE  = 2'b01,
    GRP_TWO  = 2'b11
  } disp_grp_e;

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic disp_grp_e grp_of(input logic [1:0] n);
    case (n)
      2'd2:    return GRP_TWO;
      2'd1:    return GRP_ONE;
      default: return GRP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit pool: reset/clear to SLOTS, decremented by take, refilled by give.
// Latency: give is visible in credits one cycle after it is presented.
// Backpressure: none; the consumer must never take more than credits and the
// producer must never give back more than was taken (asserted).
// Ports: clk, rst (async high), take/give (0..2), clear (restore to full), credits.
module credit_counter #(
  parameter int SLOTS = 16,
  parameter int CW    = $clog2(SLOTS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    take,
  input  logic [1:0]    give,
  input  logic          clear,
  output logic [CW-1:0] credits
);

  // One extra bit so an illegal over-release is visible rather than wrapping.
  logic [CW:0] sum;

  assign sum = {1'b0, credits} - (CW+1)'(take) + (CW+1)'(give);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CW'(SLOTS);
    end else if (clear) begin
      credits <= CW'(SLOTS);
    end else if (sum > (CW+1)'(SLOTS)) begin
      credits <= CW'(SLOTS);
    end else begin
      credits <= sum[CW-1:0];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !clear |-> (sum <= (CW+1)'(SLOTS)));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !clear |-> ((CW+1)'(take) <= {1'b0, credits}));

endmodule

// File: rtl/dispatch_scheduler.sv
// Dual-issue dispatch: in-order circular instruction queue feeding two-wide decode,
// gated by RS/ROB credits and a single LSU port (one load/store per group).
// Latency: enqueue at edge N is dispatchable in cycle N+1 at the earliest (no bypass).
// Backpressure: fetch_ready drops when fewer than two slots are free; dispatch has no
// downstream ready and is final in the cycle disp_valid is shown.
// Ports: fetch_valid/fetch_inst0/1/fetch_ready (in), disp_valid/disp_inst0/1 (out),
// rs_release/rob_retire credit returns, flush, iq_count occupancy.
module dispatch_scheduler
  import core_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int RS_SLOTS  = 16,
  parameter int ROB_SLOTS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               fetch_valid,
  input  logic [31:0]              fetch_inst0,
  input  logic [31:0]              fetch_inst1,
  output logic                     fetch_ready,
  output logic [1:0]               disp_valid,
  output logic [31:0]              disp_inst0,
  output logic [31:0]              disp_inst1,
  input  logic [1:0]               rs_release,
  input  logic [1:0]               rob_retire,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   iq_count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int RCW = $clog2(RS_SLOTS + 1);
  localparam int OCW = $clog2(ROB_SLOTS + 1);

  logic [31:0]    mem [DEPTH];
  logic [CW-1:0]  head;
  logic [CW-1:0]  tail;
  logic [CW-1:0]  count;
  logic [PW-1:0]  head_idx;
  logic [PW-1:0]  head_idx1;
  logic [PW-1:0]  tail_idx;
  logic [PW-1:0]  tail_idx1;

  logic [RCW-1:0] rs_credits;
  logic [OCW-1:0] rob_credits;
  logic [1:0]     rs_give;
  logic [1:0]     rob_give;

  logic [1:0]     occ_av;
  logic [1:0]     rs_av;
  logic [1:0]     rob_av;
  logic [1:0]     n;
  logic [1:0]     enq_n;
  disp_grp_e      grp;

  // Pointers carry a wrap bit, so the plain difference is the occupancy.
  assign count    = tail - head;
  assign iq_count = count;

  // Index arithmetic is PW bits wide so head+1 / tail+1 wrap naturally.
  assign head_idx  = head[PW-1:0];
  assign head_idx1 = head[PW-1:0] + PW'(1);
  assign tail_idx  = tail[PW-1:0];
  assign tail_idx1 = tail[PW-1:0] + PW'(1);

  // Registered occupancy only: a same-cycle dequeue does not open space.
  assign fetch_ready = (count <= CW'(DEPTH - 2));

  assign disp_inst0 = mem[head_idx];
  assign disp_inst1 = mem[head_idx1];

  always_comb begin
    occ_av = (count       >= CW'(2))  ? 2'd2 : count[1:0];
    rs_av  = (rs_credits  >= RCW'(2)) ? 2'd2 : rs_credits[1:0];
    rob_av = (rob_credits >= OCW'(2)) ? 2'd2 : rob_credits[1:0];
    n      = min2(occ_av, min2(rs_av, rob_av));
    // Single LSU port: a pair of memory ops is split across two groups.
    if (n == 2'd2 && is_mem_op(mem[head_idx][6:0]) && is_mem_op(mem[head_idx1][6:0])) begin
      n = 2'd1;
    end
    if (flush) begin
      n = 2'd0;
    end
  end

  always_comb begin
    enq_n = 2'd0;
    if (!flush && fetch_ready) begin
      case (fetch_valid)
        2'b01:   enq_n = 2'd1;
        2'b11:   enq_n = 2'd2;
        default: enq_n = 2'd0;  // 2'b10 is malformed and dropped
      endcase
    end
  end

  assign grp        = grp_of(n);
  assign disp_valid = grp;

  // Credit returns arriving in a flush cycle are superseded by the refill.
  assign rs_give  = flush ? 2'd0 : rs_release;
  assign rob_give = flush ? 2'd0 : rob_retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + CW'(n);
      tail <= tail + CW'(enq_n);
      if (enq_n != 2'd0) begin
        mem[tail_idx] <= fetch_inst0;
      end
      if (enq_n == 2'd2) begin
        mem[tail_idx1] <= fetch_inst1;
      end
    end
  end

  credit_counter #(.SLOTS(RS_SLOTS)) u_rs_credits (
    .clk     (clk),
    .rst     (rst),
    .take    (n),
    .give    (rs_give),
    .clear   (flush),
    .credits (rs_credits)
  );

  credit_counter #(.SLOTS(ROB_SLOTS)) u_rob_credits (
    .clk     (clk),
    .rst     (rst),
    .take    (n),
    .give    (rob_give),
    .clear   (flush),
    .credits (rob_credits)
  );

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Scoreboard bench for dispatch_scheduler: a queue-based reference model predicts
// each cycle's dispatch group, occupancy and fetch_ready; a negedge monitor compares.
// Directed phases (reset, LSU pairing, credit starvation, full/wrap, flush, async
// reset) are followed by a randomized phase.
module tb_dispatch_scheduler;
  import core_pkg::*;

  localparam int DEPTH     = 8;
  localparam int RS_SLOTS  = 16;
  localparam int ROB_SLOTS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  fetch_valid = 2'b00;
  logic [31:0] fetch_inst0 = '0;
  logic [31:0] fetch_inst1 = '0;
  logic        fetch_ready;
  logic [1:0]  disp_valid;
  logic [31:0] disp_inst0;
  logic [31:0] disp_inst1;
  logic [1:0]  rs_release = 2'd0;
  logic [1:0]  rob_retire = 2'd0;
  logic        flush = 1'b0;
  logic [3:0]  iq_count;

  dispatch_scheduler #(.DEPTH(DEPTH), .RS_SLOTS(RS_SLOTS), .ROB_SLOTS(ROB_SLOTS)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_inst0 (fetch_inst0),
    .fetch_inst1 (fetch_inst1),
    .fetch_ready (fetch_ready),
    .disp_valid  (disp_valid),
    .disp_inst0  (disp_inst0),
    .disp_inst1  (disp_inst1),
    .rs_release  (rs_release),
    .rob_retire  (rob_retire),
    .flush       (flush),
    .iq_count    (iq_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          n;
    logic [31:0] i0;
    logic [31:0] i1;
    int          cnt;
    logic        fr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mq[$];   // model instruction queue, oldest first
  int          rs_m;
  int          rob_m;

  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1, x0, 5
  localparam logic [31:0] I_ADD  = 32'h002081b3;  // add  x3, x1, x2
  localparam logic [31:0] I_LW   = 32'h0000a203;  // lw   x4, 0(x1)
  localparam logic [31:0] I_SW   = 32'h0040a223;  // sw   x4, 4(x1)

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_mem(input logic [31:0] inst);
    return inst[6:0] == 7'b0000011 || inst[6:0] == 7'b0100011;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [24:0] hi;
    hi = 25'($urandom());
    case ($urandom_range(0, 3))
      0:       return {hi, OPC_LOAD};
      1:       return {hi, OPC_STORE};
      2:       return {hi, OPC_RTYPE};
      default: return {hi, OPC_ITYPE};
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    rs_m  = RS_SLOTS;
    rob_m = ROB_SLOTS;
  endtask

  // Drive one cycle of inputs (called just after a rising edge), predict the
  // DUT's visible behaviour for this cycle, then advance the model to the next.
  task automatic step(input logic [1:0] fv, input logic [31:0] a, input logic [31:0] b,
                      input int rel, input int ret, input logic fl);
    exp_t e;
    int   occ;
    int   n;
    logic fr;
    occ = mq.size();
    fr  = (DEPTH - occ) >= 2;
    n   = 2;
    if (occ < n)   n = occ;
    if (rs_m < n)  n = rs_m;
    if (rob_m < n) n = rob_m;
    if (n == 2 && model_mem(mq[0]) && model_mem(mq[1])) n = 1;
    if (fl) n = 0;
    if (!fl) begin
      if (rs_m - n + rel > RS_SLOTS)   rel = RS_SLOTS - (rs_m - n);
      if (rob_m - n + ret > ROB_SLOTS) ret = ROB_SLOTS - (rob_m - n);
    end
    fetch_valid = fv;
    fetch_inst0 = a;
    fetch_inst1 = b;
    rs_release  = 2'(rel);
    rob_retire  = 2'(ret);
    flush       = fl;
    e.n   = n;
    e.i0  = (occ > 0) ? mq[0] : 32'h0;
    e.i1  = (occ > 1) ? mq[1] : 32'h0;
    e.cnt = occ;
    e.fr  = fr;
    exp_q.push_back(e);
    if (fl) begin
      model_reset();
    end else begin
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      rs_m  = rs_m - n + rel;
      rob_m = rob_m - n + ret;
      if (fr && (fv == 2'b01 || fv == 2'b11)) mq.push_back(a);
      if (fr && fv == 2'b11) mq.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_valid = 2'b00;
    rs_release  = 2'd0;
    rob_retire  = 2'd0;
    flush       = 1'b0;
  endtask

  // Monitor: compare every predicted cycle mid-period, away from the edge.
  initial begin
    exp_t e;
    logic [1:0] dv_exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        dv_exp = (e.n == 2) ? 2'b11 : (e.n == 1) ? 2'b01 : 2'b00;
        chk("disp_valid", 32'(disp_valid), 32'(dv_exp));
        chk("iq_count", 32'(iq_count), 32'(e.cnt));
        chk("fetch_ready", 32'(fetch_ready), 32'(e.fr));
        if (e.n >= 1) chk("disp_inst0", disp_inst0, e.i0);
        if (e.n == 2) chk("disp_inst1", disp_inst1, e.i1);
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_iq_count", 32'(iq_count), 32'd0);
    chk("rst_disp_inst0", disp_inst0, 32'h0);
    chk("rst_disp_inst1", disp_inst1, 32'h0);
    @(posedge clk);
    #1;

    // First pair after reset dispatches as a full group, queue drains.
    step(2'b11, I_ADDI, I_ADD, 0, 0, 1'b0);
    step(2'b00, 0, 0, 2, 2, 1'b0);
    step(2'b00, 0, 0, 2, 2, 1'b0);

    // LSU pairing: lw+sw splits, lw+add goes together.
    step(2'b11, I_LW, I_SW, 0, 0, 1'b0);
    step(2'b00, 0, 0, 0, 0, 1'b0);
    step(2'b00, 0, 0, 2, 2, 1'b0);
    step(2'b11, I_LW, I_ADD, 2, 2, 1'b0);
    step(2'b00, 0, 0, 0, 0, 1'b0);
    step(2'b00, 0, 0, 2, 2, 1'b0);
    // Illegal 2'b10 fetch must be ignored.
    step(2'b10, I_ADD, I_ADD, 2, 2, 1'b0);
    step(2'b00, 0, 0, 2, 2, 1'b0);

    // Credit starvation then fill to full with no credits returned.
    for (int i = 0; i < 14; i++) step(2'b11, I_ADD + 32'(i << 7), I_ADDI + 32'(i << 7), 0, 0, 1'b0);
    chk("full_model_depth", 32'(mq.size()), 32'(DEPTH));
    step(2'b00, 0, 0, 1, 1, 1'b0);    // one credit each back
    step(2'b00, 0, 0, 0, 0, 1'b0);    // exactly one dispatch
    for (int i = 0; i < 6; i++) step(2'b00, 0, 0, 2, 2, 1'b0);  // drain across wrap

    // Flush with five queued entries, same-cycle fetch and release discarded.
    step(2'b11, 0, 0, 2, 2, 1'b1);
    step(2'b11, I_LW, I_SW, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b11, I_SW, I_LW, 0, 0, 1'b0);
    chk("pre_flush_depth", 32'(mq.size()), 32'd5);
    step(2'b11, I_ADD, I_ADD, 1, 0, 1'b1);
    for (int i = 0; i < 9; i++) step(2'b11, I_ADD, I_ADDI, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) step(2'b00, 0, 0, 2, 2, 1'b0);

    // Async reset mid-operation with the queue half full.
    step(2'b11, 0, 0, 2, 2, 1'b1);
    step(2'b11, I_LW, I_SW, 0, 0, 1'b0);
    step(2'b11, I_SW, I_LW, 0, 0, 1'b0);
    step(2'b11, I_LW, I_SW, 0, 0, 1'b0);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("arst_disp_valid", 32'(disp_valid), 32'd0);
    chk("arst_iq_count", 32'(iq_count), 32'd0);
    chk("arst_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("arst_disp_inst0", disp_inst0, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(2'b11, I_ADDI, I_ADD, 0, 0, 1'b0);
    step(2'b00, 0, 0, 2, 2, 1'b0);
    step(2'b00, 0, 0, 0, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(2'($urandom_range(0, 3)), rand_inst(), rand_inst(),
           $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 29) == 0);
    end

    idle_inputs();
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
